// File: rtl/sort_stream_ctrl_if.sv
// Valid/ready input and output streams of the sort stream controller, plus its busy flag.
interface sort_stream_ctrl_if #(
  parameter int unsigned SIZE = 16
);
  logic            s_valid;
  logic            s_ready;
  logic [SIZE-1:0] s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [SIZE-1:0] m_data;
  logic            m_last;
  logic            busy;

  // Controller side
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, busy
  );

  // Producer/consumer side
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/sort_stream_ctrl.sv
// Frame collector, sort network hookup and descending replay of the sorted frame.

// Rank-based sort network with a registered output; slot 0 holds the largest value.
module sort #(
  parameter int unsigned NUM_VALS = 9,
  parameter int unsigned SIZE     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VALS*SIZE-1:0] in,
  output logic [NUM_VALS*SIZE-1:0] out
);
  logic [NUM_VALS*SIZE-1:0] sorted;
  int unsigned              rank;

  // Each word's slot is the count of words ahead of it; ties broken by input position.
  always_comb begin
    sorted = '0;
    rank   = 0;
    for (int i = 0; i < NUM_VALS; i++) begin
      rank = 0;
      for (int j = 0; j < NUM_VALS; j++) begin
        if (j != i) begin
          if ((in[j*SIZE +: SIZE] > in[i*SIZE +: SIZE]) ||
              ((in[j*SIZE +: SIZE] == in[i*SIZE +: SIZE]) && (j < i))) begin
            rank = rank + 1;
          end
        end
      end
      sorted[rank*SIZE +: SIZE] = in[i*SIZE +: SIZE];
    end
  end

  // One-cycle registered latency of the network.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= sorted;
  end
endmodule

module sort_stream_ctrl #(
  parameter int unsigned NUM_VALS = 9,
  parameter int unsigned SIZE     = 16
) (
  input logic              clk,
  input logic              rst,
  sort_stream_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(NUM_VALS + 1);

  typedef enum logic [1:0] {StFill, StSort, StXfer} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, len_q;
  logic [NUM_VALS*SIZE-1:0] bank_q;
  logic [NUM_VALS*SIZE-1:0] sort_out;
  logic [NUM_VALS*SIZE-1:0] buf_q;
  logic [CNT_W-1:0]         drain_len_q, rd_idx_q;
  logic                     buf_full_q;
  logic                     accept, close, m_fire, copy;

  sort #(
    .NUM_VALS(NUM_VALS),
    .SIZE    (SIZE)
  ) u_sort (
    .clk(clk),
    .rst(rst),
    .in (bank_q),
    .out(sort_out)
  );

  // s_ready is gated by rst so it is low while reset is held and high right after release.
  assign bus.s_ready = (state_q == StFill) && !rst;
  assign bus.m_valid = buf_full_q;
  assign bus.m_data  = buf_full_q ? buf_q[rd_idx_q*SIZE +: SIZE] : '0;
  assign bus.m_last  = buf_full_q && (rd_idx_q == drain_len_q - CNT_W'(1));
  assign bus.busy    = (state_q != StFill) || (count_q != '0) || buf_full_q;

  assign accept = bus.s_valid && bus.s_ready;
  assign close  = accept && (bus.s_last || (count_q == CNT_W'(NUM_VALS - 1)));
  assign m_fire = bus.m_valid && bus.m_ready;
  // A pending frame may refill the buffer on the same edge the previous frame's last beat leaves.
  assign copy   = (state_q == StXfer) && (!buf_full_q || (m_fire && bus.m_last));

  // Fill FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFill;
    else     state_q <= state_d;
  end

  // Fill FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (close) state_d = StSort;
      StSort:  state_d = StXfer;
      StXfer:  if (copy) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Bank fill; cleared on copy so slots of a short frame read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else if (copy) begin
      bank_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      bank_q[count_q*SIZE +: SIZE] <= bus.s_data;
      if (close) begin
        len_q   <= count_q + CNT_W'(1);
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Drain buffer: loaded from the sort result, read out one word per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= '0;
      drain_len_q <= '0;
      rd_idx_q    <= '0;
      buf_full_q  <= 1'b0;
    end else if (copy) begin
      buf_q       <= sort_out;
      drain_len_q <= len_q;
      rd_idx_q    <= '0;
      buf_full_q  <= 1'b1;
    end else if (m_fire) begin
      if (bus.m_last) begin
        buf_full_q <= 1'b0;
        rd_idx_q   <= '0;
      end else begin
        rd_idx_q <= rd_idx_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Directed bench for sort_stream_ctrl: frames, backpressure, overlap, reset, extremes.
module tb_sort_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  logic [15:0] frame[$];
  logic [15:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];
  int          stab_viol;

  sort_stream_ctrl_if #(.SIZE(16)) bus ();

  sort_stream_ctrl #(
    .NUM_VALS(9),
    .SIZE    (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Drive n words of frame; optional s_last on the final one. Starts and ends on a negedge.
  task automatic feed(input int n, input bit use_last);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = frame[k];
      bus.s_last  = use_last && (k == n - 1);
      while (!bus.s_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      vectors++;
      if (w >= 300) begin
        $display("FAIL feed_timeout word %0d: s_ready=%b, required 1", k, bus.s_ready);
        errors++;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 16'(($urandom));
  endtask

  // Collect n output beats; bp selects ready pattern 1,0,0,1,0,1 repeating.
  task automatic drain(input int n, input bit bp);
    int          t;
    int          ph;
    bit          hold;
    logic [15:0] hd;
    logic        hl;
    t = 0; ph = 0; hold = 0; hd = '0; hl = 1'b0;
    got_d.delete(); got_l.delete(); got_c.delete();
    stab_viol = 0;
    while (got_d.size() < n && t < 400) begin
      logic r;
      if (hold && (!bus.m_valid || bus.m_data !== hd || bus.m_last !== hl)) stab_viol++;
      r = bp ? ((ph % 6 == 0) || (ph % 6 == 3) || (ph % 6 == 5)) : 1'b1;
      ph++;
      bus.m_ready = r;
      if (bus.m_valid && r) begin
        got_d.push_back(bus.m_data);
        got_l.push_back(bus.m_last);
        got_c.push_back(t);
      end
      hold = bus.m_valid && !r;
      hd   = bus.m_data;
      hl   = bus.m_last;
      @(negedge clk);
      t++;
    end
    bus.m_ready = 1'b0;
    vectors++;
    if (got_d.size() != n) begin
      $display("FAIL drain_count: got %0d beats, required %0d", got_d.size(), n);
      errors++;
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.s_ready, bus.m_valid, bus.m_last, bus.busy} !== 4'b0000 || bus.m_data !== 16'h0) begin
      $display("FAIL reset_outputs: rdy/val/last/busy=%b data=%h, required 0000 0000",
               {bus.s_ready, bus.m_valid, bus.m_last, bus.busy}, bus.m_data);
      errors++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      $display("FAIL reset_release: s_ready=%b busy=%b m_valid=%b, required 1 0 0",
               bus.s_ready, bus.busy, bus.m_valid);
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    logic [15:0] exp[$];
    exp = '{9, 6, 6, 5, 4, 3, 3, 2, 1};
    frame = '{5, 9, 1, 3, 4, 6, 6, 3, 2};
    feed(9, 0);
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL lat_e0: m_valid=%b busy=%b, required 0 1", bus.m_valid, bus.busy);
      errors++;
    end
    @(negedge clk);
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      $display("FAIL lat_e1: m_valid=%b s_ready=%b, required 0 0", bus.m_valid, bus.s_ready);
      errors++;
    end
    @(negedge clk);
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b1 || bus.m_data !== 16'd9) begin
      $display("FAIL lat_e2: m_valid=%b s_ready=%b m_data=%0d, required 1 1 9",
               bus.m_valid, bus.s_ready, bus.m_data);
      errors++;
    end
    drain(9, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp[i] || got_l[i] !== (i == 8)) begin
        $display("FAIL full_beat%0d: data=%0d last=%b, required %0d %b",
                 i, got_d[i], got_l[i], exp[i], (i == 8));
        errors++;
      end
    end
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL full_after: m_valid=%b busy=%b, required 0 0", bus.m_valid, bus.busy);
      errors++;
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] exp[$];
    exp = '{12, 7, 0};
    frame = '{7, 0, 12};
    feed(3, 1);
    drain(3, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp[i] || got_l[i] !== (i == 2)) begin
        $display("FAIL short_beat%0d: data=%0d last=%b, required %0d %b",
                 i, got_d[i], got_l[i], exp[i], (i == 2));
        errors++;
      end
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      $display("FAIL short_extra_beat: m_valid=%b, required 0", bus.m_valid);
      errors++;
    end
    frame = '{42};
    feed(1, 1);
    drain(1, 0);
    vectors++;
    if (got_d.size() > 0 && (got_d[0] !== 16'd42 || got_l[0] !== 1'b1)) begin
      $display("FAIL single_beat: data=%0d last=%b, required 42 1", got_d[0], got_l[0]);
      errors++;
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      $display("FAIL single_extra_beat: m_valid=%b, required 0", bus.m_valid);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp[$];
    exp = '{9, 6, 6, 5, 4, 3, 3, 2, 1};
    frame = '{5, 9, 1, 3, 4, 6, 6, 3, 2};
    feed(9, 0);
    drain(9, 1);
    vectors++;
    if (stab_viol !== 0) begin
      $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", stab_viol);
      errors++;
    end
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp[i] || got_l[i] !== (i == 8)) begin
        $display("FAIL bp_beat%0d: data=%0d last=%b, required %0d %b",
                 i, got_d[i], got_l[i], exp[i], (i == 8));
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp[$];
    exp = '{9, 6, 6, 5, 4, 3, 3, 2, 1, 12, 7, 0};
    frame = '{5, 9, 1, 3, 4, 6, 6, 3, 2};
    feed(9, 0);
    frame = '{7, 0, 12};
    feed(3, 1);
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1 || bus.m_valid !== 1'b1 ||
        bus.m_data !== 16'd9) begin
      $display("FAIL b2b_pending: s_ready=%b busy=%b m_valid=%b m_data=%0d, required 0 1 1 9",
               bus.s_ready, bus.busy, bus.m_valid, bus.m_data);
      errors++;
    end
    drain(12, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp[i] || got_l[i] !== (i == 8 || i == 11)) begin
        $display("FAIL b2b_beat%0d: data=%0d last=%b, required %0d %b",
                 i, got_d[i], got_l[i], exp[i], (i == 8 || i == 11));
        errors++;
      end
    end
    for (int i = 1; i < got_c.size(); i++) begin
      vectors++;
      if (got_c[i] !== got_c[i-1] + 1) begin
        $display("FAIL b2b_gap%0d: beat at cycle %0d, required %0d", i, got_c[i], got_c[i-1] + 1);
        errors++;
      end
    end
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      $display("FAIL b2b_after: s_ready=%b m_valid=%b, required 1 0", bus.s_ready, bus.m_valid);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp[$];
    exp = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    frame = '{5, 9, 1, 3, 4, 6, 6, 3, 2};
    feed(9, 0);
    drain(4, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.s_ready, bus.m_valid, bus.m_last, bus.busy} !== 4'b0000 || bus.m_data !== 16'h0) begin
      $display("FAIL rst_drain: rdy/val/last/busy=%b data=%h, required 0000 0000",
               {bus.s_ready, bus.m_valid, bus.m_last, bus.busy}, bus.m_data);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      $display("FAIL rst_drain_rel: s_ready=%b m_valid=%b, required 1 0", bus.s_ready, bus.m_valid);
      errors++;
    end
    @(negedge clk);
    feed(5, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      $display("FAIL rst_fill: busy=%b s_ready=%b, required 0 0", bus.busy, bus.s_ready);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL rst_fill_rel: s_ready=%b busy=%b, required 1 0", bus.s_ready, bus.busy);
      errors++;
    end
    @(negedge clk);
    frame = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    feed(9, 0);
    drain(9, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp[i] || got_l[i] !== (i == 8)) begin
        $display("FAIL rst_next_beat%0d: data=%0d last=%b, required %0d %b",
                 i, got_d[i], got_l[i], exp[i], (i == 8));
        errors++;
      end
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      $display("FAIL rst_next_extra: m_valid=%b, required 0", bus.m_valid);
      errors++;
    end
  endtask

  task automatic test_extremes();
    frame = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    feed(9, 0);
    drain(9, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'hFFFF || got_l[i] !== (i == 8)) begin
        $display("FAIL ones_beat%0d: data=%h last=%b, required ffff %b",
                 i, got_d[i], got_l[i], (i == 8));
        errors++;
      end
    end
    frame = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    feed(9, 0);
    drain(9, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'h0 || got_l[i] !== (i == 8)) begin
        $display("FAIL zeros_beat%0d: data=%h last=%b, required 0000 %b",
                 i, got_d[i], got_l[i], (i == 8));
        errors++;
      end
    end
    frame = '{3, 3, 3};
    feed(3, 1);
    drain(3, 0);
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'd3 || got_l[i] !== (i == 2)) begin
        $display("FAIL dup_beat%0d: data=%0d last=%b, required 3 %b",
                 i, got_d[i], got_l[i], (i == 2));
        errors++;
      end
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      $display("FAIL dup_extra: m_valid=%b, required 0", bus.m_valid);
      errors++;
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
